// File: rtl/spart_bus_ctrl_if.sv
// spart_bus_ctrl_if
//   Processor-side I/O bus of the SPART register window.
//   Signals:
//     iocs       chip select for the 4-register window
//     iorw       1 = read, 0 = write
//     ioaddr     00 data, 01 status, 10 DB-low, 11 DB-high
//     bus_wdata  write data from the processor
//     bus_rdata  read data back to the processor
//     bus_oe     drive enable for bus_rdata
//   Modports:
//     master  processor side (drives address/control/write data)
//     slave   SPART controller side (drives read data and enable)
interface spart_bus_ctrl_if;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic [7:0] bus_wdata;
    logic [7:0] bus_rdata;
    logic       bus_oe;

    modport master (
        output iocs, iorw, ioaddr, bus_wdata,
        input  bus_rdata, bus_oe
    );

    modport slave (
        input  iocs, iorw, ioaddr, bus_wdata,
        output bus_rdata, bus_oe
    );
endinterface

// File: rtl/spart_bus_ctrl.sv
// spart_bus_ctrl
//   Processor-side controller for the SPART. Decodes the 4-register window, holds
//   the programmable baud divisor, generates the 16x-oversample baud tick, muxes
//   receive data/status onto the read bus and issues one-cycle strobes to the
//   TX (tx_load_o) and RX (rx_ack_o) engines.
//   Optional build macro: BAUD_AUTOSTART_EN -- when defined, reset loads
//   DEFAULT_DIV and the baud generator starts running without software setup.
//   Ports:
//     clk          system clock, all logic on posedge
//     rst          synchronous active-high reset
//     bus          processor bus (slave modport of spart_bus_ctrl_if)
//     rx_data_i    byte from the receive engine
//     rda_i        receive data available
//     tbr_i        transmit buffer ready
//     tx_data_o    byte to the transmit engine
//     tx_load_o    one-cycle strobe: tx_data_o valid, start transmit
//     rx_ack_o     one-cycle strobe: processor consumed rx_data_i
//     baud_en_o    one-cycle 16x baud tick
//     baud_run_o   high while the baud generator is running
//
//   Baud FSM:
//     state   | meaning
//     --------+--------------------------------------------------
//     ST_IDLE | generator stopped, counter held, no ticks
//     ST_RUN  | counter reloads from divisor, tick on terminal count
module spart_bus_ctrl #(
    parameter int                DIV_W       = 16,
    parameter logic [DIV_W-1:0]  DEFAULT_DIV = 16'd326
) (
    input  logic                    clk,
    input  logic                    rst,
    spart_bus_ctrl_if.slave         bus,
    input  logic [7:0]              rx_data_i,
    input  logic                    rda_i,
    input  logic                    tbr_i,
    output logic [7:0]              tx_data_o,
    output logic                    tx_load_o,
    output logic                    rx_ack_o,
    output logic                    baud_en_o,
    output logic                    baud_run_o
);

    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

`ifdef BAUD_AUTOSTART_EN
    localparam logic [DIV_W-1:0] RST_DIV   = DEFAULT_DIV;
    localparam logic [DIV_W-1:0] RST_CNT   = DEFAULT_DIV - ONE;
    localparam logic [7:0]       RST_STAGE = DEFAULT_DIV[7:0];
    localparam state_t           RST_STATE = ST_RUN;
`else
    localparam logic [DIV_W-1:0] RST_DIV   = '0;
    localparam logic [DIV_W-1:0] RST_CNT   = '0;
    localparam logic [7:0]       RST_STAGE = 8'h00;
    localparam state_t           RST_STATE = ST_IDLE;
`endif

    state_t             state_q, state_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               tx_load_q, tx_load_d;
    logic               rx_ack_q, rx_ack_d;
    logic               baud_en_q, baud_en_d;
    logic [7:0]         dbl_stage_q, dbl_stage_d;
    logic [DIV_W-1:0]   divisor_q, divisor_d;
    logic [DIV_W-1:0]   cnt_q, cnt_d;

    logic               rd, wr;
    logic               rd_data, wr_data, wr_dbl, wr_dbh;
    logic [DIV_W-1:0]   commit_val;
    logic               commit_nz;

    assign rd      = bus.iocs & bus.iorw;
    assign wr      = bus.iocs & ~bus.iorw;
    assign rd_data = rd & (bus.ioaddr == 2'b00);
    assign wr_data = wr & (bus.ioaddr == 2'b00);
    assign wr_dbl  = wr & (bus.ioaddr == 2'b10);
    assign wr_dbh  = wr & (bus.ioaddr == 2'b11);

    // The high-byte write commits the staged low byte together with it, so the
    // generator never sees a half-updated divisor.
    assign commit_val = {bus.bus_wdata, dbl_stage_q};
    assign commit_nz  = (commit_val != '0);

    // ---------------- read mux ----------------
    always_comb begin
        bus.bus_oe    = rd;
        bus.bus_rdata = 8'h00;
        if (rd) begin
            case (bus.ioaddr)
                2'b00:   bus.bus_rdata = rx_data_i;
                2'b01:   bus.bus_rdata = {6'b0, tbr_i, rda_i};
                2'b10:   bus.bus_rdata = divisor_q[7:0];
                default: bus.bus_rdata = divisor_q[15:8];
            endcase
        end
    end

    // ---------------- baud FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RST_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (wr_dbh) begin
            state_d = commit_nz ? ST_RUN : ST_IDLE;
        end
    end

    always_comb begin
        baud_run_o = (state_q == ST_RUN);
    end

    // ---------------- datapath ----------------
    always_comb begin
        tx_load_d   = wr_data & tbr_i;
        tx_data_d   = tx_load_d ? bus.bus_wdata : tx_data_q;
        rx_ack_d    = rd_data;
        dbl_stage_d = wr_dbl ? bus.bus_wdata : dbl_stage_q;
        divisor_d   = divisor_q;
        cnt_d       = cnt_q;
        baud_en_d   = 1'b0;
        // A commit takes priority over the terminal-count reload and suppresses
        // the tick that would otherwise land in the same cycle.
        if (wr_dbh) begin
            divisor_d = commit_val;
            if (commit_nz) begin
                cnt_d = commit_val - ONE;
            end
        end else if (state_q == ST_RUN) begin
            if (cnt_q == '0) begin
                baud_en_d = 1'b1;
                cnt_d     = divisor_q - ONE;
            end else begin
                cnt_d     = cnt_q - ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_data_q   <= 8'h00;
            tx_load_q   <= 1'b0;
            rx_ack_q    <= 1'b0;
            baud_en_q   <= 1'b0;
            dbl_stage_q <= RST_STAGE;
            divisor_q   <= RST_DIV;
            cnt_q       <= RST_CNT;
        end else begin
            tx_data_q   <= tx_data_d;
            tx_load_q   <= tx_load_d;
            rx_ack_q    <= rx_ack_d;
            baud_en_q   <= baud_en_d;
            dbl_stage_q <= dbl_stage_d;
            divisor_q   <= divisor_d;
            cnt_q       <= cnt_d;
        end
    end

    assign tx_data_o = tx_data_q;
    assign tx_load_o = tx_load_q;
    assign rx_ack_o  = rx_ack_q;
    assign baud_en_o = baud_en_q;

endmodule

// File: tb/tb_spart_bus_ctrl.sv
// tb_spart_bus_ctrl
//   Directed scenarios plus a randomized run against a behavioural model. The
//   model tracks the baud generator as "edges since the last commit" and ticks
//   whenever that count is a positive multiple of the divisor.
module tb_spart_bus_ctrl;

    localparam int DEF_DIV = 326;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rda, tbr;
    logic [7:0] tx_data;
    logic       tx_load, rx_ack, baud_en, baud_run;

    always #5 clk = ~clk;

    spart_bus_ctrl_if bus_if ();

    spart_bus_ctrl #(.DIV_W(16), .DEFAULT_DIV(16'd326)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus_if),
        .rx_data_i  (rx_data),
        .rda_i      (rda),
        .tbr_i      (tbr),
        .tx_data_o  (tx_data),
        .tx_load_o  (tx_load),
        .rx_ack_o   (rx_ack),
        .baud_en_o  (baud_en),
        .baud_run_o (baud_run)
    );

    int n_checks = 0;
    int n_errors = 0;

    // behavioural model
    bit         m_run;
    int         m_div;
    int         m_phase;
    logic [7:0] m_stage;
    logic [7:0] m_txd;
    bit         e_load, e_ack, e_tick;

    function automatic void model_edge();
        bit rd_c, wr_c;
        int val;
        if (rst) begin
            e_load = 0; e_ack = 0; e_tick = 0; m_txd = 8'h00; m_phase = 0;
`ifdef BAUD_AUTOSTART_EN
            m_run = 1; m_div = DEF_DIV; m_stage = 8'(DEF_DIV % 256);
`else
            m_run = 0; m_div = 0; m_stage = 8'h00;
`endif
            return;
        end
        rd_c = bus_if.iocs && bus_if.iorw;
        wr_c = bus_if.iocs && !bus_if.iorw;
        e_load = wr_c && bus_if.ioaddr == 2'd0 && tbr;
        if (e_load) m_txd = bus_if.bus_wdata;
        e_ack = rd_c && bus_if.ioaddr == 2'd0;
        if (wr_c && bus_if.ioaddr == 2'd3) begin
            val = int'(bus_if.bus_wdata) * 256 + int'(m_stage);
            m_div = val; m_run = (val != 0); m_phase = 0; e_tick = 0;
        end else if (m_run) begin
            m_phase++;
            e_tick = (m_phase % m_div) == 0;
        end else begin
            e_tick = 0;
        end
        if (wr_c && bus_if.ioaddr == 2'd2) m_stage = bus_if.bus_wdata;
    endfunction

    function automatic logic [7:0] exp_rdata();
        if (!(bus_if.iocs && bus_if.iorw)) return 8'h00;
        case (bus_if.ioaddr)
            2'd0:    return rx_data;
            2'd1:    return {6'b0, tbr, rda};
            2'd2:    return 8'(m_div % 256);
            default: return 8'((m_div / 256) % 256);
        endcase
    endfunction

    task automatic set_bus(input bit cs, input bit rw, input logic [1:0] a, input logic [7:0] d);
        bus_if.iocs = cs; bus_if.iorw = rw; bus_if.ioaddr = a; bus_if.bus_wdata = d;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst = 1; set_bus(0, 0, 2'd0, 8'h00);
        tick(); tick(); tick();
        rst = 0;
        n_checks++; if (tx_load !== 1'b0) begin n_errors++; $display("FAIL reset_tx_load got=%b exp=0", tx_load); end
        n_checks++; if (rx_ack !== 1'b0) begin n_errors++; $display("FAIL reset_rx_ack got=%b exp=0", rx_ack); end
        n_checks++; if (baud_en !== 1'b0) begin n_errors++; $display("FAIL reset_baud_en got=%b exp=0", baud_en); end
        n_checks++; if (tx_data !== 8'h00) begin n_errors++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
        n_checks++; if (baud_run !== m_run) begin n_errors++; $display("FAIL reset_baud_run got=%b exp=%b", baud_run, m_run); end
        n_checks++; if (bus_if.bus_oe !== 1'b0 || bus_if.bus_rdata !== 8'h00) begin
            n_errors++; $display("FAIL reset_idle_bus got=%b/%h exp=0/00", bus_if.bus_oe, bus_if.bus_rdata); end
        for (int i = 0; i < 8; i++) begin
            tick();
            n_checks++; if (baud_en !== e_tick) begin n_errors++; $display("FAIL reset_idle_tick cyc=%0d got=%b exp=%b", i, baud_en, e_tick); end
        end
    endtask

    task automatic test_baud_program();
        int first;
        first = -1;
        set_bus(1, 0, 2'd2, 8'h04); tick();
        set_bus(1, 0, 2'd3, 8'h00); tick();
        set_bus(0, 0, 2'd0, 8'h00);
        n_checks++; if (baud_run !== 1'b1) begin n_errors++; $display("FAIL prog_run got=%b exp=1", baud_run); end
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (baud_en === 1'b1 && first < 0) first = i;
            n_checks++; if (baud_en !== e_tick || baud_run !== m_run) begin
                n_errors++; $display("FAIL prog_tick cyc=%0d got=%b/%b exp=%b/%b", i, baud_en, baud_run, e_tick, m_run); end
        end
        n_checks++; if (first != 4) begin n_errors++; $display("FAIL prog_first_tick got=%0d exp=4", first); end
    endtask

    task automatic test_baud_stop();
        set_bus(1, 0, 2'd2, 8'h00); tick();
        set_bus(1, 0, 2'd3, 8'h00); tick();
        set_bus(0, 0, 2'd0, 8'h00);
        n_checks++; if (baud_run !== 1'b0) begin n_errors++; $display("FAIL stop_run got=%b exp=0", baud_run); end
        for (int i = 0; i < 12; i++) begin
            tick();
            n_checks++; if (baud_en !== 1'b0) begin n_errors++; $display("FAIL stop_tick cyc=%0d got=%b exp=0", i, baud_en); end
        end
        set_bus(1, 1, 2'd2, 8'hFF); #1;
        n_checks++; if (bus_if.bus_rdata !== 8'h00 || bus_if.bus_oe !== 1'b1) begin
            n_errors++; $display("FAIL stop_read_lo got=%h/%b exp=00/1", bus_if.bus_rdata, bus_if.bus_oe); end
        set_bus(1, 1, 2'd3, 8'hFF); #1;
        n_checks++; if (bus_if.bus_rdata !== 8'h00) begin n_errors++; $display("FAIL stop_read_hi got=%h exp=00", bus_if.bus_rdata); end
        tick();
        n_checks++; if (rx_ack !== 1'b0) begin n_errors++; $display("FAIL stop_no_ack got=%b exp=0", rx_ack); end
        set_bus(0, 0, 2'd0, 8'h00); tick();
    endtask

    task automatic test_tx();
        tbr = 1; set_bus(1, 0, 2'd0, 8'hA5); tick();
        set_bus(0, 0, 2'd0, 8'h00);
        n_checks++; if (tx_load !== 1'b1 || tx_data !== 8'hA5) begin
            n_errors++; $display("FAIL tx_load got=%b/%h exp=1/a5", tx_load, tx_data); end
        tick();
        n_checks++; if (tx_load !== 1'b0) begin n_errors++; $display("FAIL tx_one_cycle got=%b exp=0", tx_load); end
        tbr = 0; set_bus(1, 0, 2'd0, 8'h5A); tick();
        n_checks++; if (tx_load !== 1'b0 || tx_data !== 8'hA5) begin
            n_errors++; $display("FAIL tx_dropped got=%b/%h exp=0/a5", tx_load, tx_data); end
        tbr = 1; set_bus(1, 0, 2'd0, 8'h11); tick();
        n_checks++; if (tx_load !== 1'b1 || tx_data !== 8'h11) begin
            n_errors++; $display("FAIL tx_b2b_1 got=%b/%h exp=1/11", tx_load, tx_data); end
        set_bus(1, 0, 2'd0, 8'h22); tick();
        n_checks++; if (tx_load !== 1'b1 || tx_data !== 8'h22) begin
            n_errors++; $display("FAIL tx_b2b_2 got=%b/%h exp=1/22", tx_load, tx_data); end
        set_bus(1, 0, 2'd1, 8'h77); tick();
        n_checks++; if (tx_load !== 1'b0 || tx_data !== 8'h22) begin
            n_errors++; $display("FAIL tx_status_wr got=%b/%h exp=0/22", tx_load, tx_data); end
        set_bus(0, 0, 2'd0, 8'h00); tick();
    endtask

    task automatic test_rx_status();
        rda = 1; rx_data = 8'h3C; tbr = 1;
        set_bus(1, 1, 2'd0, 8'h00); #1;
        n_checks++; if (bus_if.bus_rdata !== 8'h3C || bus_if.bus_oe !== 1'b1) begin
            n_errors++; $display("FAIL rx_read got=%h/%b exp=3c/1", bus_if.bus_rdata, bus_if.bus_oe); end
        tick();
        set_bus(0, 0, 2'd0, 8'h00);
        n_checks++; if (rx_ack !== 1'b1) begin n_errors++; $display("FAIL rx_ack got=%b exp=1", rx_ack); end
        tick();
        n_checks++; if (rx_ack !== 1'b0) begin n_errors++; $display("FAIL rx_ack_one got=%b exp=0", rx_ack); end
        set_bus(1, 1, 2'd1, 8'h00); #1;
        n_checks++; if (bus_if.bus_rdata !== 8'h03) begin n_errors++; $display("FAIL status_read got=%h exp=03", bus_if.bus_rdata); end
        rda = 0; set_bus(1, 1, 2'd0, 8'h00); tick();
        n_checks++; if (rx_ack !== 1'b1) begin n_errors++; $display("FAIL rx_ack_no_rda got=%b exp=1", rx_ack); end
        set_bus(0, 0, 2'd0, 8'h00); tick();
    endtask

    task automatic test_commit_on_tick();
        set_bus(1, 0, 2'd2, 8'h08); tick();
        set_bus(1, 0, 2'd3, 8'h00); tick();
        set_bus(1, 0, 2'd2, 8'h02); tick();
        set_bus(0, 0, 2'd0, 8'h00);
        for (int i = 2; i <= 7; i++) tick();
        // next edge is the divisor-8 terminal count
        set_bus(1, 0, 2'd3, 8'h00); tick();
        set_bus(0, 0, 2'd0, 8'h00);
        n_checks++; if (baud_en !== 1'b0) begin n_errors++; $display("FAIL commit_tick_suppressed got=%b exp=0", baud_en); end
        for (int i = 1; i <= 10; i++) begin
            tick();
            n_checks++; if (baud_en !== ((i % 2) == 0) || baud_en !== e_tick) begin
                n_errors++; $display("FAIL commit_new_period cyc=%0d got=%b exp=%b", i, baud_en, (i % 2) == 0); end
        end
    endtask

    task automatic test_reset_mid();
        tbr = 1; rst = 1; set_bus(1, 0, 2'd0, 8'h99); tick();
        rst = 0; set_bus(0, 0, 2'd0, 8'h00);
        n_checks++; if (tx_load !== 1'b0 || tx_data !== 8'h00 || baud_en !== 1'b0 || baud_run !== m_run) begin
            n_errors++; $display("FAIL mid_reset got=%b/%h/%b/%b exp=0/00/0/%b", tx_load, tx_data, baud_en, baud_run, m_run); end
    endtask

    task automatic test_random();
        logic [1:0] a;
        logic [7:0] d;
        for (int i = 0; i < 600; i++) begin
            a = 2'($urandom_range(0, 3));
            d = 8'($urandom);
            if (a == 2'd2) d = 8'($urandom_range(0, 12));
            if (a == 2'd3) d = ($urandom_range(0, 9) == 0) ? 8'h01 : 8'h00;
            rst = ($urandom_range(0, 149) == 0);
            tbr = 1'($urandom); rda = 1'($urandom); rx_data = 8'($urandom);
            set_bus(($urandom_range(0, 3) == 0), 1'($urandom), a, d);
            #1;
            n_checks++; if (bus_if.bus_rdata !== exp_rdata() || bus_if.bus_oe !== (bus_if.iocs & bus_if.iorw)) begin
                n_errors++; $display("FAIL rand_rdata cyc=%0d got=%h/%b exp=%h", i, bus_if.bus_rdata, bus_if.bus_oe, exp_rdata()); end
            tick();
            n_checks++; if (tx_load !== e_load || tx_data !== m_txd || rx_ack !== e_ack || baud_en !== e_tick || baud_run !== m_run) begin
                n_errors++;
                $display("FAIL rand_outputs cyc=%0d got=%b/%h/%b/%b/%b exp=%b/%h/%b/%b/%b",
                         i, tx_load, tx_data, rx_ack, baud_en, baud_run, e_load, m_txd, e_ack, e_tick, m_run);
            end
        end
        rst = 0; set_bus(0, 0, 2'd0, 8'h00); tick();
    endtask

    initial begin
        rst = 1; rx_data = 8'h00; rda = 0; tbr = 0;
        set_bus(0, 0, 2'd0, 8'h00);
        test_reset();
        test_baud_program();
        test_baud_stop();
        test_tx();
        test_rx_status();
        test_commit_on_tick();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
